// File: rtl/fpu_seq_pkg.sv
// Shared types and constants for the FP operation sequencer.
package fpu_seq_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    SHOW  = 2'd3
  } seq_state_e;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [2:0] LAST_BYTE = 3'd7;
  localparam logic [1:0] LAST_PAGE = 2'd3;

  // Result page sequence used by auto-scroll: 3 returns to 0 explicitly.
  function automatic logic [1:0] next_page(input logic [1:0] p);
    logic [1:0] n;
    if (p == LAST_PAGE) begin
      n = 2'd0;
    end else begin
      n = p + 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/fpu_op_sequencer_enter_edge_det.sv
// Rising-edge detector for the enter button; history resets high so a button
// held through reset release does not count as a press.
module enter_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q_r;

  // Previous level register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      level_q_r <= 1'b1;
    end else begin
      level_q_r <= level;
    end
  end

  assign rise = level & ~level_q_r;

endmodule

// File: rtl/fpu_op_sequencer.sv
// Sequences operand entry, one FP-unit operation and paging of the result.
// Optional build macro FPU_SEQ_AUTO_SCROLL_EN adds timed result-page scrolling.
module fpu_op_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SCROLL_CYCLES  = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter,
  input  logic [1:0] op_sel,
  input  logic       alu_done,
  output logic       alu_start,
  output logic [1:0] alu_op,
  output logic       loaddata,
  output logic [2:0] byte_index,
  output logic [1:0] page,
  output logic       busy,
  output logic       timeout
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  seq_state_e      state_r, state_s;
  logic [TO_W-1:0] to_cnt_r, to_cnt_s;
  logic [2:0]      byte_index_r, byte_index_s;
  logic [1:0]      page_r, page_s;
  logic [1:0]      alu_op_r, alu_op_s;
  logic            timeout_r, timeout_s;
  logic            alu_start_r, alu_start_s;
  logic            busy_r, busy_s;
  logic            loaddata_r, loaddata_s;
  logic            enter_edge_s;

`ifdef FPU_SEQ_AUTO_SCROLL_EN
  localparam int SC_W = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCROLL_CYCLES - 1);
  logic [SC_W-1:0] sc_cnt_r, sc_cnt_s;
`endif

  enter_edge_det u_enter_edge (
    .clk   (clk),
    .reset (reset),
    .level (enter),
    .rise  (enter_edge_s)
  );

  // Next-state and next-output logic; outputs follow the next state so they are registered.
  always_comb begin
    state_s      = state_r;
    to_cnt_s     = to_cnt_r;
    byte_index_s = byte_index_r;
    page_s       = page_r;
    alu_op_s     = alu_op_r;
    timeout_s    = timeout_r;
`ifdef FPU_SEQ_AUTO_SCROLL_EN
    sc_cnt_s     = sc_cnt_r;
`endif
    case (state_r)
      LOAD: begin
        if (enter_edge_s) begin
          if (byte_index_r == LAST_BYTE) begin
            state_s = ISSUE;
          end else begin
            byte_index_s = byte_index_r + 3'd1;
          end
        end else begin
          state_s = LOAD;
        end
      end
      ISSUE: begin
        alu_op_s = op_sel;
        to_cnt_s = '0;
        state_s  = WAIT;
      end
      WAIT: begin
        // Completion takes priority over a simultaneous timeout expiry.
        if (alu_done) begin
          state_s = SHOW;
          page_s  = 2'd0;
        end else if (to_cnt_r == TO_LAST) begin
          state_s   = SHOW;
          page_s    = 2'd0;
          timeout_s = 1'b1;
        end else begin
          to_cnt_s = to_cnt_r + TO_W'(1);
        end
`ifdef FPU_SEQ_AUTO_SCROLL_EN
        sc_cnt_s = '0;
`endif
      end
      SHOW: begin
        if (enter_edge_s) begin
          if (page_r == LAST_PAGE) begin
            state_s      = LOAD;
            byte_index_s = 3'd0;
            page_s       = 2'd0;
            timeout_s    = 1'b0;
          end else begin
            page_s = page_r + 2'd1;
          end
`ifdef FPU_SEQ_AUTO_SCROLL_EN
          sc_cnt_s = '0;
        end else if (sc_cnt_r == SC_LAST) begin
          sc_cnt_s = '0;
          page_s   = next_page(page_r);
        end else begin
          sc_cnt_s = sc_cnt_r + SC_W'(1);
        end
`else
        end else begin
          page_s = page_r;
        end
`endif
      end
      default: begin
        state_s = LOAD;
      end
    endcase

    alu_start_s = (state_s == ISSUE);
    busy_s      = (state_s == ISSUE) || (state_s == WAIT);
    loaddata_s  = (state_s == LOAD);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= LOAD;
      to_cnt_r     <= '0;
      byte_index_r <= 3'd0;
      page_r       <= 2'd0;
      alu_op_r     <= 2'd0;
      timeout_r    <= 1'b0;
      alu_start_r  <= 1'b0;
      busy_r       <= 1'b0;
      loaddata_r   <= 1'b1;
    end else begin
      state_r      <= state_s;
      to_cnt_r     <= to_cnt_s;
      byte_index_r <= byte_index_s;
      page_r       <= page_s;
      alu_op_r     <= alu_op_s;
      timeout_r    <= timeout_s;
      alu_start_r  <= alu_start_s;
      busy_r       <= busy_s;
      loaddata_r   <= loaddata_s;
    end
  end

`ifdef FPU_SEQ_AUTO_SCROLL_EN
  // Scroll timer register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sc_cnt_r <= '0;
    end else begin
      sc_cnt_r <= sc_cnt_s;
    end
  end
`endif

  assign alu_start  = alu_start_r;
  assign alu_op     = alu_op_r;
  assign loaddata   = loaddata_r;
  assign byte_index = byte_index_r;
  assign page       = page_r;
  assign busy       = busy_r;
  assign timeout    = timeout_r;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench: behavioural model compared every cycle, plus directed literal checks.
module tb_fpu_op_sequencer;

  localparam int TO = 16;
  localparam int SC = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       enter;
  logic [1:0] op_sel;
  logic       alu_done;
  logic       alu_start;
  logic [1:0] alu_op;
  logic       loaddata;
  logic [2:0] byte_index;
  logic [1:0] page;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: phase 0=entering operands, 1=start pulse, 2=waiting, 3=showing result
  int m_phase, m_bi, m_page, m_to, m_op, m_wait, m_scroll;
  bit m_prev;

  fpu_op_sequencer #(.TIMEOUT_CYCLES(TO), .SCROLL_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .enter(enter), .op_sel(op_sel), .alu_done(alu_done),
    .alu_start(alu_start), .alu_op(alu_op), .loaddata(loaddata), .byte_index(byte_index),
    .page(page), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit e;
    if (!reset) begin
      m_phase = 0; m_bi = 0; m_page = 0; m_to = 0; m_op = 0;
      m_wait = 0; m_scroll = 0; m_prev = 1'b1;
    end else begin
      e = enter && !m_prev;
      m_prev = enter;
      case (m_phase)
        0: if (e) begin
             if (m_bi == 7) m_phase = 1;
             else m_bi = m_bi + 1;
           end
        1: begin m_op = op_sel; m_wait = 0; m_phase = 2; end
        2: begin
             m_wait = m_wait + 1;
             if (alu_done) begin
               m_phase = 3; m_page = 0; m_scroll = 0;
             end else if (m_wait == TO) begin
               m_phase = 3; m_page = 0; m_to = 1; m_scroll = 0;
             end
           end
        3: begin
             if (e) begin
               if (m_page == 3) begin
                 m_phase = 0; m_bi = 0; m_page = 0; m_to = 0;
               end else begin
                 m_page = m_page + 1;
               end
               m_scroll = 0;
             end
`ifdef FPU_SEQ_AUTO_SCROLL_EN
             else begin
               m_scroll = m_scroll + 1;
               if (m_scroll == SC) begin
                 m_scroll = 0;
                 m_page = (m_page + 1) % 4;
               end
             end
`endif
           end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("alu_start",  alu_start,  m_phase == 1);
      chk("busy",       busy,       (m_phase == 1) || (m_phase == 2));
      chk("loaddata",   loaddata,   m_phase == 0);
      chk("byte_index", byte_index, m_bi);
      chk("page",       page,       m_page);
      chk("timeout",    timeout,    m_to);
      chk("alu_op",     alu_op,     m_op);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press();
    enter = 1'b1; tick();
    enter = 1'b0; tick();
  endtask

  // Enters 8 bytes; returns on the cycle the start pulse is visible.
  task automatic load8(input logic [1:0] op);
    op_sel = op;
    repeat (7) press();
    enter = 1'b1; tick();
    enter = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_loaddata"}, loaddata, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_bi"}, byte_index, 0);
    chk({tag, "_page"}, page, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_alu_op"}, alu_op, 0);
    chk({tag, "_start"}, alu_start, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int n;
    int hold;
    reset = 1'b0; enter = 1'b0; op_sel = 2'd0; alu_done = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk_reset_vals("rst");
    reset = 1'b1;
    tick();

    // Operand entry, start pulse, done after 5 cycles, page through result
    op_sel = 2'd2;
    for (int k = 1; k <= 7; k++) begin
      press();
      chk("entry_bi", byte_index, k);
    end
    enter = 1'b1; tick();
    chk("issue_start", alu_start, 1);
    chk("issue_busy", busy, 1);
    chk("issue_loaddata", loaddata, 0);
    chk("issue_bi", byte_index, 7);
    enter = 1'b0; tick();
    chk("wait_op", alu_op, 2);
    chk("wait_start", alu_start, 0);
    chk("wait_busy", busy, 1);
    repeat (3) tick();
    alu_done = 1'b1; tick();
    alu_done = 1'b0;
    chk("done_busy", busy, 0);
    chk("done_page", page, 0);
    chk("done_timeout", timeout, 0);
    for (int p = 1; p <= 3; p++) begin
      press();
      chk("show_page", page, p);
    end
    press();
    chk("back_loaddata", loaddata, 1);
    chk("back_bi", byte_index, 0);

    // Timeout path: no alu_done
    load8(2'd3);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (busy) n++;
      else break;
    end
    chk("timeout_wait_cycles", n, 16);
    chk("timeout_flag", timeout, 1);
    chk("timeout_op", alu_op, 3);
    repeat (4) press();
    chk("timeout_cleared", timeout, 0);
    chk("timeout_loaddata", loaddata, 1);

    // Held enter counts once; enter held across reset release counts zero
    enter = 1'b1;
    repeat (20) tick();
    enter = 1'b0; tick();
    chk("held_bi", byte_index, 1);
    enter = 1'b1; reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (5) tick();
    enter = 1'b0; tick();
    chk("reset_held_bi", byte_index, 0);

    // Reset during WAIT, with a late alu_done
    load8(2'd1);
    tick(); tick();
    reset = 1'b0; tick();
    reset = 1'b1; alu_done = 1'b1; tick();
    alu_done = 1'b0; tick();
    chk_reset_vals("midrst");

`ifdef FPU_SEQ_AUTO_SCROLL_EN
    load8(2'd1);
    tick();
    alu_done = 1'b1; tick();
    alu_done = 1'b0;
    for (int k = 0; k <= 24; k++) begin
      if (k == 0 || k == 7) chk("scroll_page", page, 0);
      if (k == 8) chk("scroll_page", page, 1);
      if (k == 16) chk("scroll_page", page, 2);
      if (k == 24) chk("scroll_page", page, 3);
      if (k < 24) tick();
    end
    enter = 1'b1; tick();
    enter = 1'b0;
    chk("scroll_back_loaddata", loaddata, 1);
    tick();
`endif

    // Randomized traffic against the model
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) != 0);
      if (hold == 0) begin
        enter = $urandom_range(0, 1);
        hold = $urandom_range(1, 4);
      end else begin
        hold--;
      end
      op_sel = 2'($urandom_range(0, 3));
      alu_done = ($urandom_range(0, 11) == 0);
      tick();
    end
    reset = 1'b1; enter = 1'b0; alu_done = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
